// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector to a combinational
// unit, samples its response on the last hold cycle and tallies mismatches.
module truth_table_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int HOLD  = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_cnt,
    output logic             fail_valid,
    output logic [N_IN-1:0]  first_fail
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [HW-1:0]   hold_cnt;
    logic [N_OUT-1:0] exp_resp;
    logic            sample;
    logic            last_vec;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    // abort outranks the sample edge, so an aborted vector is never scored
    always_comb begin
        exp_resp   = EXPECT[int'(stim)*N_OUT +: N_OUT];
        sample     = (state == DRIVE) && !abort && (hold_cnt == LAST_HOLD);
        last_vec   = &stim;
        mismatch   = sample && (resp != exp_resp);
        err_next   = err_cnt + (N_IN+1)'(mismatch);
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE: begin
                if (abort)                    state_next = IDLE;
                else if (sample && last_vec)  state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim       <= '0;
            hold_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stim       <= '0;
                        hold_cnt   <= '0;
                        busy       <= 1'b1;
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end else if (!sample) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end else begin
                        err_cnt <= err_next;
                        if (mismatch && !fail_valid) begin
                            first_fail <= stim;
                            fail_valid <= 1'b1;
                        end
                        if (last_vec) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (err_next == '0);
                        end else begin
                            stim     <= stim + N_IN'(1);
                            hold_cnt <= '0;
                        end
                    end
                end
                FINISH: done <= 1'b0;
                default: done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: directed and randomised fault sweeps on a
// HOLD=1 instance plus a HOLD=3 instance with off-sample response noise.
module tb_truth_table_sweeper;

    function automatic logic [1:0] ref_f(input logic [3:0] v);
        return {v[3] ^ v[2], v[1] & v[0]};
    endfunction

    function automatic logic [31:0] build_exp();
        logic [31:0] e;
        e = '0;
        for (int v = 0; v < 16; v++) e[v*2 +: 2] = ref_f(4'(v));
        return e;
    endfunction

    localparam logic [31:0] EXP_TT = build_exp();

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [1:0] resp1;
    logic [3:0] stim1, first_fail1;
    logic       busy1, done1, pass1, fail_valid1;
    logic [4:0] err_cnt1;
    logic [1:0] fault [16];

    logic       start2 = 1'b0, abort2 = 1'b0;
    logic [1:0] resp2, noise2;
    logic [3:0] stim2, first_fail2;
    logic       busy2, done2, pass2, fail_valid2;
    logic [4:0] err_cnt2;

    assign resp1 = ref_f(stim1) ^ fault[stim1];
    assign resp2 = ref_f(stim2) ^ noise2;

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .HOLD(1), .EXPECT(EXP_TT)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .resp(resp1),
        .stim(stim1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
        .fail_valid(fail_valid1), .first_fail(first_fail1)
    );

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .HOLD(3), .EXPECT(EXP_TT)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .resp(resp2),
        .stim(stim2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .fail_valid(fail_valid2), .first_fail(first_fail2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: errors are simply the vectors whose injected fault is non-zero.
    task automatic model(output int e, output int ff);
        bit found;
        e = 0; ff = 0; found = 0;
        for (int v = 0; v < 16; v++) begin
            if (fault[v] != 2'b00) begin
                e++;
                if (!found) ff = v;
                found = 1;
            end
        end
    endtask

    task automatic clear_faults();
        for (int v = 0; v < 16; v++) fault[v] = 2'b00;
    endtask

    task automatic start_sweep1(input bit keep_high);
        start1 = 1'b1;
        tick();
        if (!keep_high) start1 = 1'b0;
        chk("start_busy", busy1, 1);
        chk("start_stim", stim1, 0);
        chk("start_err", err_cnt1, 0);
        chk("start_fv", fail_valid1, 0);
        chk("start_pass", pass1, 0);
    endtask

    task automatic run_to_done1(input string tag);
        int k, e, ff;
        k = 0;
        while (busy1 && k < 100) begin
            chk({tag, "_stim"}, stim1, 32'(k));
            chk({tag, "_nodone"}, done1, 0);
            tick();
            k++;
        end
        model(e, ff);
        chk({tag, "_busy_len"}, k, 16);
        chk({tag, "_done"}, done1, 1);
        chk({tag, "_pass"}, pass1, (e == 0) ? 1 : 0);
        chk({tag, "_err"}, err_cnt1, e);
        chk({tag, "_fv"}, fail_valid1, (e != 0) ? 1 : 0);
        if (e != 0) chk({tag, "_ff"}, first_fail1, ff);
        chk({tag, "_stim_end"}, stim1, 15);
        tick();
        chk({tag, "_done_off"}, done1, 0);
        chk({tag, "_busy_off"}, busy1, 0);
    endtask

    initial begin
        int k;
        clear_faults();
        noise2 = 2'b00;

        // Reset state
        tick(); tick();
        chk("rst_stim1", stim1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_pass1", pass1, 0);
        chk("rst_err1", err_cnt1, 0);
        chk("rst_fv1", fail_valid1, 0);
        chk("rst_ff1", first_fail1, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_stim2", stim2, 0);
        rst_n = 1'b1;
        tick();

        // Clean sweep
        start_sweep1(0);
        run_to_done1("clean");

        // Faults at vectors 5 and 9
        fault[5] = 2'b01;
        fault[9] = 2'b01;
        start_sweep1(0);
        run_to_done1("fault59");
        chk("fault59_ff_direct", first_fail1, 5);
        chk("fault59_err_direct", err_cnt1, 2);

        // Randomised fault patterns
        for (int r = 0; r < 8; r++) begin
            for (int v = 0; v < 16; v++)
                fault[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            start_sweep1(0);
            run_to_done1("rand");
        end

        // Abort at stim==7 with a fault at vector 2
        clear_faults();
        fault[2] = 2'b01;
        start_sweep1(0);
        k = 0;
        while (stim1 != 4'd7 && k < 40) begin tick(); k++; end
        chk("abort_reach7", stim1, 7);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_stim_hold", stim1, 7);
        chk("abort_err", err_cnt1, 1);
        chk("abort_ff", first_fail1, 2);
        chk("abort_fv", fail_valid1, 1);
        chk("abort_pass", pass1, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_nodone", done1, 0);
            tick();
        end
        chk("abort_idle_stim", stim1, 7);
        start_sweep1(0);
        run_to_done1("after_abort");

        // Asynchronous reset mid-sweep
        start_sweep1(0);
        k = 0;
        while (stim1 != 4'd10 && k < 40) begin tick(); k++; end
        chk("rst_reach10", stim1, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stim", stim1, 0);
        chk("arst_busy", busy1, 0);
        chk("arst_err", err_cnt1, 0);
        chk("arst_fv", fail_valid1, 0);
        chk("arst_ff", first_fail1, 0);
        chk("arst_pass", pass1, 0);
        chk("arst_done", done1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_sweep1(0);
        run_to_done1("after_rst");

        // start held high across a faulty sweep, then a clean re-triggered one
        clear_faults();
        fault[3] = 2'b10;
        start_sweep1(1);
        run_to_done1("held");
        tick();
        chk("retrig_busy", busy1, 1);
        chk("retrig_stim", stim1, 0);
        chk("retrig_err", err_cnt1, 0);
        chk("retrig_fv", fail_valid1, 0);
        start1 = 1'b0;
        clear_faults();
        run_to_done1("retrig");

        // HOLD=3 with noise on the non-sample cycles
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        k = 0;
        while (busy2 && k < 300) begin
            chk("h3_stim", stim2, 32'(k / 3));
            noise2 = (k % 3 == 2) ? 2'b00 : 2'($urandom_range(1, 3));
            tick();
            k++;
        end
        noise2 = 2'b00;
        chk("h3_busy_len", k, 48);
        chk("h3_done", done2, 1);
        chk("h3_pass", pass2, 1);
        chk("h3_err", err_cnt2, 0);
        chk("h3_fv", fail_valid2, 0);
        tick();
        chk("h3_done_off", done2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Synthesisable, parametrised exhaustive-test engine for small combinational blocks.
- On `start`, drives every input vector 0..2^N_IN-1 onto `stim`, holds each vector HOLD cycles, and samples the DUT response `resp` on the last hold cycle.
- Compares each sample against a packed expected truth table, counts mismatching vectors, and latches the first failing vector.
- Replaces hand-written per-vector stimulus sequences; sits between a board/bench controller and any N_IN-in / N_OUT-out combinational unit.

Parameters:
- N_IN, 4: number of DUT inputs; sweep length 2^N_IN vectors; legal 1..10.
- N_OUT, 2: number of DUT outputs compared per vector; legal 1..8.
- HOLD, 1: cycles each vector is held; response sampled on the last one; legal ≥1.
- EXPECT, all zeros, width N_OUT*2^N_IN: expected response for vector v is EXPECT[v*N_OUT +: N_OUT].

Ports:
- clk  in  1  Single clock; all state changes on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- start  in  1  Level sampled in IDLE; a high sample begins a sweep.
- abort  in  1  Synchronous; terminates a sweep and returns to IDLE.
- resp  in  N_OUT  DUT response; combinational from `stim`.
- stim  out  N_IN  Registered vector driven to the DUT.
- busy  out  1  High while sweeping.
- done  out  1  One-cycle pulse when a sweep completes normally.
- pass  out  1  High when the last completed sweep had err_cnt==0.
- err_cnt  out  N_IN+1  Number of mismatching vectors in the current/last sweep.
- fail_valid  out  1  Set on the first mismatch of the sweep.
- first_fail  out  N_IN  Vector index of the first mismatch; valid while fail_valid=1.

Behaviour:
- Reset (async assert, any state, including mid-sweep): state=IDLE; stim=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, first_fail=0, hold_cnt=0. Takes effect immediately.
- States: IDLE, DRIVE, FINISH.
- IDLE:
  - start=1 → DRIVE. Same edge: stim←0, hold_cnt←0, busy←1, err_cnt←0, fail_valid←0, first_fail←0, pass←0.
  - start=0: remain in IDLE; all results hold their values.
- DRIVE, per edge:
  - If hold_cnt<HOLD-1: hold_cnt++.
  - Else (sample edge): compare resp with EXPECT slice for the current stim.
    - Mismatch: err_cnt++. If fail_valid=0, also first_fail←stim and fail_valid←1.
    - If stim=all-ones → FINISH with busy←0. Otherwise stim++ and hold_cnt←0.
- FINISH: lasts exactly one cycle.
  - done=1; pass=(err_cnt==0) is registered and visible in this cycle.
  - → IDLE next edge, done←0.
- Timing: busy is high for exactly 2^N_IN*HOLD cycles after the start edge; done rises on the following edge.
- Comparison is per vector: any bit differing counts as one error. err_cnt max is 2^N_IN, so no overflow or saturation logic is needed.
- start while busy or in FINISH: ignored.
- A new start in IDLE clears all previous results.
- abort=1 in DRIVE: → IDLE next edge with busy←0; no done pulse; pass stays 0; err_cnt, fail_valid and first_fail keep their partial values; stim holds its last value.
- abort in IDLE or FINISH: no effect; FINISH still pulses done.
- abort and start together in IDLE: start wins; the sweep begins.
- stim only changes on sample edges, so it never glitches within a hold window.
- Final vector (all-ones) is compared before exit. stim does not wrap to 0 at the end; it stays all-ones until the next start.

Test Plan:
- Clean sweep. Defaults with HOLD=1; resp={stim[3]^stim[2], stim[1]&stim[0]}; EXPECT built from the same function. Pulse start → stim steps 0..15 one per cycle; busy high 16 cycles; done pulse in cycle 17; pass=1; err_cnt=0; fail_valid=0.
- Injected faults. Same setup but resp bit0 inverted when stim==5 or stim==9 → err_cnt=2, first_fail=5, fail_valid=1, pass=0 at done.
- HOLD=3. Clean model → each stim value held 3 cycles; busy 48 cycles; done on the 49th; pass=1. Changing resp during non-sample cycles has no effect on err_cnt.
- Abort. Fault at vector 2; assert abort while stim==7 → IDLE next cycle; no done pulse; err_cnt=1, first_fail=2, pass=0. A new start clears err_cnt to 0 and restarts at stim=0.
- Reset mid-sweep. Drop rst_n asynchronously at stim==10 → all outputs 0 immediately. After release, start gives a full 16-vector sweep.
- start held high through the whole sweep → only one sweep runs during busy. It re-triggers in IDLE the cycle after done, and that second sweep clears results.
